// File: rtl/fetch_dispatch.sv
// Instruction fetch unit: requests cache lines, scans one word per cycle, resolves
// jumps and bgt branches locally, and queues issuable instructions for dispatch.
module fetch_dispatch #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 32,
  parameter int PC_W       = 32,
  parameter int QDEPTH     = 8,
  parameter int REG_W      = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         line_req,
  output logic [PC_W-1:0]              line_addr,
  input  logic                         line_valid,
  input  logic [LINE_WORDS*WORD_W-1:0] line_data,
  output logic                         disp_valid,
  input  logic                         disp_ready,
  output logic [WORD_W-1:0]            disp_inst,
  output logic [PC_W-1:0]              disp_pc,
  output logic [REG_W-1:0]             rd_addr0,
  output logic [REG_W-1:0]             rd_addr1,
  input  logic                         rd_ready0,
  input  logic                         rd_ready1,
  input  logic signed [WORD_W-1:0]     rd_data0,
  input  logic signed [WORD_W-1:0]     rd_data1,
  output logic                         halted,
  output logic [$clog2(QDEPTH):0]      q_count
);
  localparam int WB    = WORD_W / 8;
  localparam int WB_W  = $clog2(WB);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + WB_W;
  localparam int QA_W  = $clog2(QDEPTH);
  localparam int CNT_W = QA_W + 1;
  localparam int JO_W  = WORD_W - 4;
  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(WB);
  localparam logic [PC_W-1:0] LINE_MASK = PC_W'((1 << OFF_W) - 1);
  localparam logic [PC_W-1:0] TGT_MASK  = ~PC_W'(3);

  localparam logic [3:0] OP_HALT = 4'b0001, OP_ADD = 4'b1000, OP_MUL = 4'b1001;
  localparam logic [3:0] OP_BGT  = 4'b1010, OP_LW  = 4'b1100, OP_SW  = 4'b1101;
  localparam logic [3:0] OP_JUMP = 4'b1110, OP_MV  = 4'b1111;

  typedef enum logic [1:0] {REQ, SCAN, BR_WAIT, HALT} state_t;

  state_t                     state_reg, state_next;
  logic [PC_W-1:0]            pc_reg, pc_next;
  logic [IDX_W-1:0]           idx_reg, idx_next;
  logic [LINE_WORDS*WORD_W-1:0] line_reg;
  logic [REG_W-1:0]           rd_addr0_reg, rd_addr0_next, rd_addr1_reg, rd_addr1_next;
  logic                       halted_reg, halted_next;
  logic [QA_W-1:0]            head_reg, tail_reg;
  logic [CNT_W-1:0]           count_reg;
  logic [WORD_W-1:0]          fifo_inst [QDEPTH];
  logic [PC_W-1:0]            fifo_pc   [QDEPTH];

  logic [WORD_W-1:0] line_words [LINE_WORDS];
  logic [WORD_W-1:0] cur_inst;
  logic [3:0]        opcode;
  logic [PC_W-1:0]   pc_seq, jump_tgt, br_tgt;
  logic              last_word, is_issue, can_enq, enq, deq, line_take;

  // Word 0 of a line occupies the most significant bits.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
    assign line_words[gi] = line_reg[(LINE_WORDS-1-gi)*WORD_W +: WORD_W];
  end

  assign cur_inst  = line_words[idx_reg];
  assign opcode    = cur_inst[WORD_W-1 -: 4];
  assign last_word = (idx_reg == IDX_W'(LINE_WORDS - 1));
  assign pc_seq    = pc_reg + PC_STEP;
  assign jump_tgt  = (pc_reg + {{(PC_W-JO_W){cur_inst[JO_W-1]}}, cur_inst[JO_W-1:0]}) & TGT_MASK;
  assign br_tgt    = (pc_reg + {{(PC_W-16){cur_inst[15]}}, cur_inst[15:0]}) & TGT_MASK;
  assign is_issue  = (opcode == OP_ADD) || (opcode == OP_MUL) || (opcode == OP_LW) ||
                     (opcode == OP_SW)  || (opcode == OP_MV);
  assign deq       = disp_valid && disp_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign can_enq   = (count_reg != CNT_W'(QDEPTH)) || deq;
  assign enq       = (state_reg == SCAN) && (is_issue || opcode == OP_HALT) && can_enq;
  assign line_take = (state_reg == REQ) && line_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= REQ;
      pc_reg       <= '0;
      idx_reg      <= '0;
      line_reg     <= '0;
      rd_addr0_reg <= '0;
      rd_addr1_reg <= '0;
      halted_reg   <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      idx_reg      <= idx_next;
      rd_addr0_reg <= rd_addr0_next;
      rd_addr1_reg <= rd_addr1_next;
      halted_reg   <= halted_next;
      if (line_take) line_reg <= line_data;
      if (enq) tail_reg <= tail_reg + 1'b1;
      if (deq) head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_inst[tail_reg] <= cur_inst;
      fifo_pc[tail_reg]   <= pc_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    idx_next      = idx_reg;
    rd_addr0_next = rd_addr0_reg;
    rd_addr1_next = rd_addr1_reg;
    halted_next   = halted_reg;
    case (state_reg)
      REQ: begin
        if (line_valid) begin
          idx_next   = pc_reg[OFF_W-1:WB_W];
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (opcode == OP_JUMP) begin
          pc_next    = jump_tgt;
          state_next = REQ;
        end else if (opcode == OP_BGT) begin
          rd_addr0_next = cur_inst[WORD_W-5 -: REG_W];
          rd_addr1_next = cur_inst[WORD_W-5-REG_W -: REG_W];
          state_next    = BR_WAIT;
        end else if (opcode == OP_HALT) begin
          if (can_enq) begin
            halted_next = 1'b1;
            state_next  = HALT;
          end
        end else if (!is_issue || can_enq) begin
          pc_next    = pc_seq;
          idx_next   = idx_reg + 1'b1;
          state_next = last_word ? REQ : SCAN;
        end
      end
      BR_WAIT: begin
        // Wait for older instructions to leave the queue so their producers are visible.
        if (count_reg == '0 && rd_ready0 && rd_ready1) begin
          if (rd_data0 > rd_data1) begin
            pc_next    = br_tgt;
            state_next = REQ;
          end else begin
            pc_next    = pc_seq;
            idx_next   = idx_reg + 1'b1;
            state_next = last_word ? REQ : SCAN;
          end
        end
      end
      default: state_next = HALT;
    endcase
  end

  always_comb begin
    line_req   = (state_reg == REQ) && !rst;
    line_addr  = pc_reg & ~LINE_MASK;
    disp_valid = (count_reg != '0);
    disp_inst  = disp_valid ? fifo_inst[head_reg] : '0;
    disp_pc    = disp_valid ? fifo_pc[head_reg] : '0;
    rd_addr0   = rd_addr0_reg;
    rd_addr1   = rd_addr1_reg;
    halted     = halted_reg;
    q_count    = count_reg;
  end
endmodule

// File: tb/tb_fetch_dispatch.sv
// Directed bench for fetch_dispatch: a line-addressed instruction memory answers
// requests, and a monitor records every line handshake and every dispatch.
module tb_fetch_dispatch;
  logic                clk = 1'b0;
  logic                rst;
  logic                line_req;
  logic [31:0]         line_addr;
  logic                line_valid;
  logic [1023:0]       line_data;
  logic                disp_valid;
  logic                disp_ready;
  logic [31:0]         disp_inst;
  logic [31:0]         disp_pc;
  logic [5:0]          rd_addr0, rd_addr1;
  logic                rd_ready0, rd_ready1;
  logic signed [31:0]  rd_data0, rd_data1;
  logic                halted;
  logic [3:0]          q_count;

  logic [31:0] imem [256];
  logic [63:0] dq [$];
  logic [31:0] req_addrs [$];
  int          nreq;
  int          checks = 0;
  int          errors = 0;

  localparam logic [31:0] HALT_I = 32'h1000_0000;
  localparam logic [31:0] BGT_I  = 32'hA042_0010;

  fetch_dispatch dut (
    .clk(clk), .rst(rst), .line_req(line_req), .line_addr(line_addr),
    .line_valid(line_valid), .line_data(line_data), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_inst(disp_inst), .disp_pc(disp_pc),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_ready0(rd_ready0),
    .rd_ready1(rd_ready1), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .halted(halted), .q_count(q_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    line_data = '0;
    for (int i = 0; i < 32; i++)
      line_data[(31-i)*32 +: 32] = imem[{line_addr[9:7], 5'(i)}];
  end

  always @(posedge clk) begin
    if (rst) begin
      nreq = 0;
      dq.delete();
      req_addrs.delete();
    end else begin
      if (line_req && line_valid) begin
        nreq++;
        req_addrs.push_back(line_addr);
      end
      if (disp_valid && disp_ready) dq.push_back({disp_inst, disp_pc});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic reset_dut();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("rst_line_req", 64'(line_req), 64'd0);
    chk("rst_disp_valid", 64'(disp_valid), 64'd0);
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_outs", {rd_addr0, rd_addr1, disp_inst, disp_pc}, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; disp_ready = 1'b1; line_valid = 1'b1;
    rd_ready0 = 1'b1; rd_ready1 = 1'b1; rd_data0 = 0; rd_data1 = 0;

    // Straight line with a delayed cache hit
    clear_mem();
    imem[0] = 32'h8000_0001; imem[1] = 32'h9000_0002; imem[2] = 32'hC000_0003; imem[3] = HALT_I;
    line_valid = 1'b0;
    reset_dut();
    run(3);
    chk("req_held", {31'd0, line_req, line_addr}, {31'd0, 1'b1, 32'd0});
    chk("req_none_yet", 64'(nreq), 64'd0);
    line_valid = 1'b1;
    run(1);
    chk("scan_no_req", {62'd0, line_req, disp_valid}, 64'd0);
    run(1);
    chk("first_disp", {31'd0, disp_valid, disp_inst, 32'd0} | 64'(disp_pc), {31'd0, 1'b1, 32'h8000_0001, 32'd0});
    chk("first_qcnt", 64'(q_count), 64'd1);
    run(15);
    chk("sl_count", 64'(dq.size()), 64'd4);
    chk("sl_d0", dq[0], {32'h8000_0001, 32'd0});
    chk("sl_d1", dq[1], {32'h9000_0002, 32'd4});
    chk("sl_d2", dq[2], {32'hC000_0003, 32'd8});
    chk("sl_d3", dq[3], {HALT_I, 32'd12});
    chk("sl_halted", {63'd0, halted}, 64'd1);
    chk("sl_nreq", 64'(nreq), 64'd1);

    // Line crossing
    clear_mem();
    for (int k = 0; k < 32; k++) imem[k] = 32'h8000_0000 + 32'(k);
    imem[32] = HALT_I;
    reset_dut();
    run(50);
    chk("lx_nreq", 64'(nreq), 64'd2);
    chk("lx_addr1", 64'(req_addrs[1]), 64'd128);
    chk("lx_count", 64'(dq.size()), 64'd33);
    chk("lx_last_add", dq[31], {32'h8000_001F, 32'd124});
    chk("lx_first_new", dq[32], {HALT_I, 32'd128});

    // Jump backwards by 8
    clear_mem();
    imem[0] = 32'h8000_0001; imem[1] = 32'h8000_0002; imem[2] = 32'hEFFF_FFF8;
    reset_dut();
    run(8);
    chk("jb_req_addr", 64'(req_addrs[1]), 64'd0);
    chk("jb_size_ok", 64'(dq.size() >= 3), 64'd1);
    chk("jb_restart", dq[2], {32'h8000_0001, 32'd0});

    // Jump by offset 0x0FFFFFFC (-4) from pc 0 wraps to the top of the address space
    clear_mem();
    imem[0] = 32'hEFFF_FFFC; imem[255] = HALT_I;
    reset_dut();
    run(10);
    chk("jw_req_addr", 64'(req_addrs[1]), 64'hFFFF_FF80);
    chk("jw_disp", dq[0], {HALT_I, 32'hFFFF_FFFC});

    // bgt taken: 5 > 3 at pc 20, offset +16
    clear_mem();
    imem[5] = BGT_I; imem[6] = 32'h8000_0006; imem[7] = HALT_I;
    imem[9] = 32'h9000_0009; imem[10] = HALT_I;
    rd_data0 = 5; rd_data1 = 3;
    reset_dut();
    run(15);
    chk("bt_nreq", 64'(nreq), 64'd2);
    chk("bt_d0", dq[0], {32'h9000_0009, 32'd36});
    chk("bt_d1", dq[1], {HALT_I, 32'd40});

    // bgt not taken (3 vs 5) with rd_ready0 held low
    rd_data0 = 3; rd_data1 = 5; rd_ready0 = 1'b0;
    reset_dut();
    run(15);
    chk("bh_rd_addr", {52'd0, rd_addr0, rd_addr1}, {52'd0, 6'd1, 6'd2});
    chk("bh_no_redirect", {32'(nreq), 32'(dq.size())}, {32'd1, 32'd0});
    chk("bh_no_req", 64'(line_req), 64'd0);
    rd_ready0 = 1'b1;
    run(10);
    chk("bn_nreq", 64'(nreq), 64'd1);
    chk("bn_d0", dq[0], {32'h8000_0006, 32'd24});
    chk("bn_d1", dq[1], {HALT_I, 32'd28});

    // Backpressure: 10 adds into an 8-entry queue
    clear_mem();
    for (int k = 0; k < 10; k++) imem[k] = 32'h8000_0000 + 32'(k);
    imem[10] = HALT_I;
    disp_ready = 1'b0;
    reset_dut();
    run(20);
    chk("bp_qfull", 64'(q_count), 64'd8);
    chk("bp_head", {disp_inst, disp_pc}, {32'h8000_0000, 32'd0});
    chk("bp_not_halted", 64'(halted), 64'd0);
    disp_ready = 1'b1;
    run(20);
    chk("bp_count", 64'(dq.size()), 64'd11);
    for (int k = 0; k < 10; k++)
      chk($sformatf("bp_d%0d", k), dq[k], {32'h8000_0000 + 32'(k), 32'(4 * k)});
    chk("bp_halt", dq[10], {HALT_I, 32'd40});
    chk("bp_drained", 64'(q_count), 64'd0);

    // Reset while waiting on a branch with three queued entries
    clear_mem();
    imem[0] = 32'h8000_0000; imem[1] = 32'h8000_0001; imem[2] = 32'h8000_0002; imem[3] = BGT_I;
    disp_ready = 1'b0; rd_data0 = 5; rd_data1 = 3;
    reset_dut();
    run(12);
    chk("mr_qcount", 64'(q_count), 64'd3);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    #1;
    chk("mr_after", {30'd0, disp_valid, line_req, 28'd0, q_count}, {30'd0, 1'b0, 1'b1, 32'd0});
    chk("mr_addr", 64'(line_addr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
